// File: rtl/sr_pkg.sv
// Shared op codes, FSM state encoding and sizing helper for the SR latch driver.
package sr_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        CHECK = 2'b10,
        GAP   = 2'b11
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module sr_pulse_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Command sequencer producing exclusive, fixed-width S/R pulses for an SR latch
// and confirming the result from the latch Q/Q_bar feedback.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 1,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    output logic       S,
    output logic       R,
    input  logic       q_fb,
    input  logic       q_bar_fb,
    output logic       done,
    output logic       err,
    output logic       q_state,
    output logic       busy
);

    localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, TIMEOUT) + 1);
    // Timer is loaded with N-1 so that a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] L_CHECK = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP_W - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_s, r_r, r_done, r_err, r_q_state, r_target;
    logic             w_s_next, w_r_next, w_done_next, w_err_next;
    logic             w_q_state_next, w_target_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;
    logic             w_accept;
    logic             w_match;

    sr_pulse_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    // Equal feedback lines (00/11) never count as a valid latch state.
    assign w_match   = (q_fb == r_target) && (q_bar_fb == !r_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_q_state <= 1'b0;
            r_target  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_s       <= w_s_next;
            r_r       <= w_r_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
            r_q_state <= w_q_state_next;
            r_target  <= w_target_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_s_next       = 1'b0;
        w_r_next       = 1'b0;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        w_q_state_next = r_q_state;
        w_target_next  = r_target;
        w_load         = 1'b0;
        w_load_val     = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_op == OP_NOP) begin
                        w_state_next = GAP;
                        w_load       = 1'b1;
                        w_load_val   = L_GAP;
                        w_done_next  = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_SET:   w_target_next = 1'b1;
                            OP_RESET: w_target_next = 1'b0;
                            default:  w_target_next = !q_fb;
                        endcase
                        w_state_next = PULSE;
                        w_load       = 1'b1;
                        w_load_val   = L_PULSE;
                        w_s_next     = w_target_next;
                        w_r_next     = !w_target_next;
                    end
                end
            end
            PULSE: begin
                if (w_zero) begin
                    w_state_next = CHECK;
                    w_load       = 1'b1;
                    w_load_val   = L_CHECK;
                end else begin
                    w_s_next = r_s;
                    w_r_next = r_r;
                end
            end
            CHECK: begin
                if (w_match) begin
                    w_state_next   = GAP;
                    w_load         = 1'b1;
                    w_load_val     = L_GAP;
                    w_done_next    = 1'b1;
                    w_q_state_next = r_target;
                end else if (w_zero) begin
                    w_state_next = GAP;
                    w_load       = 1'b1;
                    w_load_val   = L_GAP;
                    w_done_next  = 1'b1;
                    w_err_next   = 1'b1;
                end
            end
            GAP: begin
                if (w_zero) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign S       = r_s;
    assign R       = r_r;
    assign done    = r_done;
    assign err     = r_err;
    assign q_state = r_q_state;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR latch on the feedback path.
module tb_sr_latch_driver;

    localparam int PW = 4;
    localparam int GW = 1;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready, S, R, done, err, q_state, busy;
    logic       q_fb, q_bar_fb;
    logic       latch_q = 1'b0;
    logic       stuck = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    always @* begin
        if (S && !R)      latch_q = 1'b1;
        else if (R && !S) latch_q = 1'b0;
    end
    assign q_fb     = stuck ? 1'b0 : latch_q;
    assign q_bar_fb = stuck ? 1'b0 : ~latch_q;

    sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .S         (S),
        .R         (R),
        .q_fb      (q_fb),
        .q_bar_fb  (q_bar_fb),
        .done      (done),
        .err       (err),
        .q_state   (q_state),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) chk("s_and_r_exclusive", int'(S & R), 0);

    // Waits (bounded) for cmd_ready at a negedge, then presents op for one accept edge.
    task automatic issue(input logic [1:0] op, input string name);
        int n = 0;
        while (!cmd_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        $display("txn %s accepted at t=%0t", name, $time);
    endtask

    task automatic run_pulse(input logic exp_s, input int exp_wait,
                             input logic exp_err, input logic exp_q);
        int n = 0;
        for (int k = 0; k < PW; k++) begin
            @(negedge clk);
            chk("pulse_s", int'(S), int'(exp_s));
            chk("pulse_r", int'(R), int'(!exp_s));
        end
        @(negedge clk);
        while (!done && n < TO + 4) begin
            chk("check_no_drive", int'({S, R}), 0);
            n++;
            @(negedge clk);
        end
        chk("check_cycles", n, exp_wait);
        chk("done", int'(done), 1);
        chk("err", int'(err), int'(exp_err));
        chk("q_state", int'(q_state), int'(exp_q));
        chk("ready_in_gap", int'(cmd_ready), 0);
        for (int k = 0; k < GW; k++) @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("ready_back", int'(cmd_ready), 1);
    endtask

    initial begin
        int n;
        #2;
        chk("rst_S", int'(S), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_qstate", int'(q_state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        issue(sr_pkg::OP_SET, "SET");
        run_pulse(1'b1, 1, 1'b0, 1'b1);

        issue(sr_pkg::OP_RESET, "RESET");
        run_pulse(1'b0, 1, 1'b0, 1'b0);
        chk("latch_q_low", int'(q_fb), 0);
        chk("latch_qb_high", int'(q_bar_fb), 1);

        issue(sr_pkg::OP_TOGGLE, "TOGGLE1");
        run_pulse(1'b1, 1, 1'b0, 1'b1);
        issue(sr_pkg::OP_TOGGLE, "TOGGLE2");
        run_pulse(1'b0, 1, 1'b0, 1'b0);

        stuck = 1'b1;
        issue(sr_pkg::OP_SET, "SET_STUCK");
        run_pulse(1'b1, TO, 1'b1, 1'b0);
        stuck = 1'b0;

        // NOP followed by a held-valid SET.
        cmd_valid = 1'b1;
        cmd_op    = sr_pkg::OP_NOP;
        @(posedge clk);
        #1 cmd_op = sr_pkg::OP_SET;
        $display("txn NOP accepted at t=%0t", $time);
        @(negedge clk);
        chk("nop_done", int'(done), 1);
        chk("nop_err", int'(err), 0);
        chk("nop_no_drive", int'({S, R}), 0);
        chk("nop_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        chk("nop_ready_back", int'(cmd_ready), 1);
        chk("nop_done_clear", int'(done), 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        $display("txn SET_HELD accepted at t=%0t", $time);
        @(negedge clk);
        chk("held_set_s", int'(S), 1);
        chk("held_set_busy", int'(busy), 1);
        n = 0;
        while (!done && n < PW + TO + 4) begin
            @(negedge clk);
            n++;
        end
        chk("held_set_done", int'(done), 1);
        chk("held_set_err", int'(err), 0);
        chk("held_set_q", int'(q_state), 1);
        @(negedge clk);

        // Reset asserted during the second PULSE cycle.
        issue(sr_pkg::OP_SET, "SET_ABORT");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_S", int'(S), 0);
        chk("abort_R", int'(R), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 0);
        chk("abort_qstate", int'(q_state), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        $display("txn RESET_RELEASE at t=%0t", $time);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_ready", int'(cmd_ready), 1);
            chk("post_rst_no_done", int'(done), 0);
            chk("post_rst_no_drive", int'({S, R}), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
